uart_alu_ctrl: RTL

UART_ALU_CTRL -- requirements
Module: uart_alu_ctrl

---
 rtl/uart_alu_ctrl.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/uart_alu_ctrl.sv
// ---------------------------------------------------------------------------
// uart_alu_ctrl
//   Command sequencer between a byte-oriented UART and a combinational ALU.
//   A command is three received bytes: operand A, operand B, opcode. The
//   controller presents them to the ALU, captures the result (or ERR_BYTE for
//   an unknown opcode), requests one transmission and waits for the UART
//   transmitter to finish before accepting the next command. A partially
//   received command is discarded if the gap between its bytes is too long.
//
// Ports
//   i_clk         system clock, rising edge
//   i_rst         asynchronous active-high reset
//   i_rx_done     one-cycle pulse, new received byte on i_rx_data
//   i_rx_data     received byte
//   i_tx_done     one-cycle pulse, transmitter finished a byte
//   i_alu_result  combinational ALU result for o_alu_a/o_alu_b/o_alu_op
//   o_alu_a/b     registered operands
//   o_alu_op      registered opcode (low OP_W bits of the third byte)
//   o_tx_start    one-cycle request to transmit o_tx_data
//   o_tx_data     byte to transmit, held stable until the next command
//   o_busy        high whenever the sequencer is not idle
//   o_err_op      one-cycle pulse, opcode not recognised
//   o_timeout     one-cycle pulse, command abandoned on inter-byte timeout
//   o_overrun     sticky, a byte arrived while no byte could be accepted
// ---------------------------------------------------------------------------
module uart_alu_ctrl #(
    parameter int                 DATA_W      = 8,
    parameter int                 OP_W        = 6,
    parameter int                 TIMEOUT_CYC = 1000000,
    parameter logic [DATA_W-1:0]  ERR_BYTE    = 8'hEE
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_rx_done,
    input  logic [DATA_W-1:0] i_rx_data,
    input  logic              i_tx_done,
    input  logic [DATA_W-1:0] i_alu_result,
    output logic [DATA_W-1:0] o_alu_a,
    output logic [DATA_W-1:0] o_alu_b,
    output logic [OP_W-1:0]   o_alu_op,
    output logic              o_tx_start,
    output logic [DATA_W-1:0] o_tx_data,
    output logic              o_busy,
    output logic              o_err_op,
    output logic              o_timeout,
    output logic              o_overrun
);

    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    localparam logic [OP_W-1:0] OP_ADD = OP_W'('h20);
    localparam logic [OP_W-1:0] OP_SUB = OP_W'('h22);
    localparam logic [OP_W-1:0] OP_AND = OP_W'('h24);
    localparam logic [OP_W-1:0] OP_OR  = OP_W'('h25);
    localparam logic [OP_W-1:0] OP_XOR = OP_W'('h26);
    localparam logic [OP_W-1:0] OP_NOR = OP_W'('h27);
    localparam logic [OP_W-1:0] OP_SRA = OP_W'('h03);
    localparam logic [OP_W-1:0] OP_SRL = OP_W'('h02);

    typedef enum logic [2:0] {
        IDLE,
        GET_B,
        GET_OP,
        EXEC,
        SEND,
        WAIT_TX
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] gap_cnt;

    function automatic logic op_valid(input logic [OP_W-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_NOR, OP_SRA, OP_SRL: op_valid = 1'b1;
            default:                        op_valid = 1'b0;
        endcase
    endfunction

    // NOTE: all state and outputs are updated with non-blocking assignments so
    // every register samples pre-edge values, independent of statement order.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= IDLE;
            gap_cnt    <= '0;
            o_alu_a    <= '0;
            o_alu_b    <= '0;
            o_alu_op   <= '0;
            o_tx_start <= 1'b0;
            o_tx_data  <= '0;
            o_busy     <= 1'b0;
            o_err_op   <= 1'b0;
            o_timeout  <= 1'b0;
            o_overrun  <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low here and are raised only in the
            // branch that fires them, which guarantees a single-cycle width.
            o_tx_start <= 1'b0;
            o_err_op   <= 1'b0;
            o_timeout  <= 1'b0;

            if (i_rx_done && (state == EXEC || state == SEND || state == WAIT_TX))
                o_overrun <= 1'b1;

            case (state)
                IDLE: begin
                    if (i_rx_done) begin
                        o_alu_a <= i_rx_data;
                        gap_cnt <= '0;
                        o_busy  <= 1'b1;
                        state   <= GET_B;
                    end
                end

                // A byte arriving on the expiry cycle is checked first, so it
                // wins over the timeout.
                GET_B: begin
                    if (i_rx_done) begin
                        o_alu_b <= i_rx_data;
                        gap_cnt <= '0;
                        state   <= GET_OP;
                    end else if (gap_cnt == CNT_LAST) begin
                        o_timeout <= 1'b1;
                        gap_cnt   <= '0;
                        o_busy    <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end

                GET_OP: begin
                    if (i_rx_done) begin
                        o_alu_op <= i_rx_data[OP_W-1:0];
                        gap_cnt  <= '0;
                        state    <= EXEC;
                    end else if (gap_cnt == CNT_LAST) begin
                        o_timeout <= 1'b1;
                        gap_cnt   <= '0;
                        o_busy    <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end

                // Operands are registered, so the ALU result is settled here.
                // The start request is registered on this edge so that it is
                // high exactly during SEND.
                EXEC: begin
                    if (op_valid(o_alu_op)) begin
                        o_tx_data <= i_alu_result;
                    end else begin
                        o_tx_data <= ERR_BYTE;
                        o_err_op  <= 1'b1;
                    end
                    o_tx_start <= 1'b1;
                    state      <= SEND;
                end

                SEND: begin
                    state <= WAIT_TX;
                end

                WAIT_TX: begin
                    if (i_tx_done) begin
                        o_busy <= 1'b0;
                        state  <= IDLE;
                    end
                end

                default: begin
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule
